// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the decode control bundle.
//   ctrl_bundle_t : packed {wre, wme, wb_sel[1:0], alu_op[3:0]} (8 bits)
//   CTRL_NOP      : all-zero bundle used as the pipeline bubble
//   WB_SEL_*      : writeback mux encodings
//   ALU_*         : ALU operation encodings
//   OP_*          : complete bundles emitted by decode for each instruction
package ctrl_pkg;

  typedef struct packed {
    logic       wre;
    logic       wme;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = 8'h00;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h91;  // wre, wb_sel=ALU, add
  localparam logic [7:0] OP_BE  = 8'h02;  // compare only, no writeback
  localparam logic [7:0] OP_LDR = 8'h81;  // wre, wb_sel=MEM, add for address
  localparam logic [7:0] OP_STR = 8'h40;  // wme only

  // A load is the only producer whose result is not ready for forwarding
  // out of EX, which is what makes it a hazard source.
  function automatic logic is_load(input ctrl_bundle_t b);
    return b.wre & (b.wb_sel == WB_SEL_MEM);
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one pipeline register holding a control bundle and its rd.
//   clk, rst_n : clock, asynchronous active-low clear to the NOP bundle
//   bubble     : synchronous load of the NOP bundle instead of the input
//   ctrl_d/rd_d: incoming bundle and destination register
//   ctrl_q/rd_q: registered bundle and destination register
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  ctrl_bundle_t      ctrl_d,
  input  logic [REG_AW-1:0] rd_d,
  output ctrl_bundle_t      ctrl_q,
  output logic [REG_AW-1:0] rd_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
      rd_q   <= '0;
    end else if (bubble) begin
      ctrl_q <= CTRL_NOP;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decode control bundle through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards and inserts bubbles on stall or flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_ctrl_i, id_rd_i  : bundle and destination from decode
//   id_rs1_i/id_rs2_i   : sources of the ID instruction, with *_used_i flags
//   branch_taken_i      : branch resolved taken in EX (flush)
//   stall_o, flush_o    : hold PC and IF/ID / clear IF/ID
//   ex_*, mem_*, wb_*   : unpacked per-stage fields for the datapath
//   bubble_cnt_o        : saturating count of stall/flush bubbles
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        id_ctrl_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [3:0]        ex_alu_op_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              mem_wme_o,
  output logic              mem_wre_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic              wb_wre_o,
  output logic [1:0]        wb_sel_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  ctrl_bundle_t      id_ctrl;
  ctrl_bundle_t      ctrl_p0, ctrl_p1, ctrl_p2;
  logic [REG_AW-1:0] rd_p0, rd_p1, rd_p2;
  logic              ex_is_load;
  logic              rs1_hit, rs2_hit;
  logic              idex_bubble;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              unused_wb_fields;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign id_ctrl = ctrl_bundle_t'(id_ctrl_i);

  // Hazard check: ID sources against the load sitting in EX. A taken branch
  // discards the ID instruction, so there is nothing to hold.
  assign ex_is_load  = is_load(ctrl_p0);
  assign rs1_hit     = id_rs1_used_i & (id_rs1_i == rd_p0);
  assign rs2_hit     = id_rs2_used_i & (id_rs2_i == rd_p0);
  assign stall_o     = ex_is_load & ~branch_taken_i & (rs1_hit | rs2_hit);
  assign flush_o     = branch_taken_i;
  assign idex_bubble = branch_taken_i | stall_o;

  // ---- ID -> EX (p0): the only stage that can take a bubble ----
  ctrl_stage_reg #(.REG_AW(REG_AW)) u_idex (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (idex_bubble),
    .ctrl_d (id_ctrl),
    .rd_d   (id_rd_i),
    .ctrl_q (ctrl_p0),
    .rd_q   (rd_p0)
  );

  // ---- EX -> MEM (p1): always advances ----
  ctrl_stage_reg #(.REG_AW(REG_AW)) u_exmem (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .ctrl_d (ctrl_p0),
    .rd_d   (rd_p0),
    .ctrl_q (ctrl_p1),
    .rd_q   (rd_p1)
  );

  // ---- MEM -> WB (p2): always advances ----
  ctrl_stage_reg #(.REG_AW(REG_AW)) u_memwb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .ctrl_d (ctrl_p1),
    .rd_d   (rd_p1),
    .ctrl_q (ctrl_p2),
    .rd_q   (rd_p2)
  );

  // Counts only bubbles this block inserts; NOPs from decode are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (idex_bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign ex_alu_op_o  = ctrl_p0.alu_op;
  assign ex_rd_o      = rd_p0;
  assign mem_wme_o    = ctrl_p1.wme;
  assign mem_wre_o    = ctrl_p1.wre;
  assign mem_rd_o     = rd_p1;
  assign wb_wre_o     = ctrl_p2.wre;
  assign wb_sel_o     = ctrl_p2.wb_sel;
  assign wb_rd_o      = rd_p2;
  assign bubble_cnt_o = bubble_cnt;

  // WB has no use for the memory-write or ALU fields.
  assign unused_wb_fields = ^{ctrl_p2.wme, ctrl_p2.alu_op};

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] id_ctrl;
  logic [3:0] id_rd, id_rs1, id_rs2;
  logic       rs1_used, rs2_used, br;

  logic       stall, flush, mem_wme, mem_wre, wb_wre;
  logic [3:0] ex_alu_op, ex_rd, mem_rd, wb_rd;
  logic [1:0] wb_sel;
  logic [15:0] cnt;

  logic       s_stall, s_flush, s_mem_wme, s_mem_wre, s_wb_wre;
  logic [3:0] s_ex_alu_op, s_ex_rd, s_mem_rd, s_wb_rd;
  logic [1:0] s_wb_sel;
  logic [1:0] s_cnt;

  logic [22:0] dut_vec, sat_vec;

  int checks = 0;
  int errors = 0;

  // reference model: what occupies EX, MEM, WB as {ctrl[7:0], rd[3:0]}
  logic [11:0] hist [0:2];
  int unsigned bubbles;

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl_i(id_ctrl), .id_rd_i(id_rd),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(rs1_used),
    .id_rs2_used_i(rs2_used), .branch_taken_i(br), .stall_o(stall),
    .flush_o(flush), .ex_alu_op_o(ex_alu_op), .ex_rd_o(ex_rd),
    .mem_wme_o(mem_wme), .mem_wre_o(mem_wre), .mem_rd_o(mem_rd),
    .wb_wre_o(wb_wre), .wb_sel_o(wb_sel), .wb_rd_o(wb_rd),
    .bubble_cnt_o(cnt)
  );

  ctrl_pipe #(.REG_AW(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_ctrl_i(id_ctrl), .id_rd_i(id_rd),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(rs1_used),
    .id_rs2_used_i(rs2_used), .branch_taken_i(br), .stall_o(s_stall),
    .flush_o(s_flush), .ex_alu_op_o(s_ex_alu_op), .ex_rd_o(s_ex_rd),
    .mem_wme_o(s_mem_wme), .mem_wre_o(s_mem_wre), .mem_rd_o(s_mem_rd),
    .wb_wre_o(s_wb_wre), .wb_sel_o(s_wb_sel), .wb_rd_o(s_wb_rd),
    .bubble_cnt_o(s_cnt)
  );

  assign dut_vec = {stall, flush, ex_alu_op, ex_rd, mem_wme, mem_wre, mem_rd,
                    wb_wre, wb_sel, wb_rd};
  assign sat_vec = {s_stall, s_flush, s_ex_alu_op, s_ex_rd, s_mem_wme, s_mem_wre,
                    s_mem_rd, s_wb_wre, s_wb_sel, s_wb_rd};

  // ---------------- reference model ----------------
  function automatic bit model_stall();
    logic [11:0] ex;
    bit load;
    ex = hist[0];
    load = (ex[11] == 1'b1) && (ex[9:8] == 2'b00);
    return load && !br &&
           ((rs1_used && id_rs1 == ex[3:0]) || (rs2_used && id_rs2 == ex[3:0]));
  endfunction

  function automatic logic [22:0] exp_vec();
    return {model_stall(), br, hist[0][7:4], hist[0][3:0],
            hist[1][10], hist[1][11], hist[1][3:0],
            hist[2][11], hist[2][9:8], hist[2][3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    bubbles = 0;
  endtask

  // advance the model by one clock with the current inputs, then move to
  // the next falling edge
  task automatic cycle();
    bit bub;
    bub = br || model_stall();
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = bub ? 12'h000 : {id_ctrl, id_rd};
    if (bub) bubbles++;
    @(negedge clk);
  endtask

  task automatic set_in(input logic [7:0] c, input logic [3:0] rd,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic u2, input logic b);
    id_ctrl = c; id_rd = rd; id_rs1 = s1; id_rs2 = s2;
    rs1_used = u1; rs2_used = u2; br = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_in(8'h91, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dut_vec !== 23'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    checks++;
    if (cnt !== 16'd0 || s_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt, s_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ex_alu_op !== 4'd1 || ex_rd !== 4'd5) begin
      errors++;
      $display("FAIL reset_release_capture: got alu=%0d rd=%0d expected alu=1 rd=5",
               ex_alu_op, ex_rd);
    end
  endtask

  task automatic test_add_flow();
    do_reset();
    set_in(8'h91, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ex_alu_op !== 4'd1 || ex_rd !== 4'd5) begin
      errors++;
      $display("FAIL add_ex: got alu=%0d rd=%0d expected alu=1 rd=5", ex_alu_op, ex_rd);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_wre !== 1'b1 || mem_rd !== 4'd5 || mem_wme !== 1'b0) begin
      errors++;
      $display("FAIL add_mem: got wre=%0b rd=%0d wme=%0b expected wre=1 rd=5 wme=0",
               mem_wre, mem_rd, mem_wme);
    end
    @(negedge clk); #1;
    checks++;
    if (wb_wre !== 1'b1 || wb_sel !== 2'b01 || wb_rd !== 4'd5) begin
      errors++;
      $display("FAIL add_wb: got wre=%0b sel=%b rd=%0d expected wre=1 sel=01 rd=5",
               wb_wre, wb_sel, wb_rd);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(8'h81, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(8'h91, 4'd6, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall_on: got %0b expected 1", stall);
    end
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || ex_alu_op !== 4'd0 || ex_rd !== 4'd0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_bubble: got stall=%0b alu=%0d rd=%0d cnt=%0d expected 0 0 0 1",
               stall, ex_alu_op, ex_rd, cnt);
    end
    @(negedge clk);
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ex_alu_op !== 4'd1 || ex_rd !== 4'd6 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_add_in_ex: got alu=%0d rd=%0d cnt=%0d expected 1 6 1",
               ex_alu_op, ex_rd, cnt);
    end
  endtask

  task automatic test_no_hazard();
    for (int v = 0; v < 2; v++) begin
      do_reset();
      set_in(8'h81, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (v == 0) set_in(8'h91, 4'd6, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      else        set_in(8'h91, 4'd6, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL nohaz_stall_%0d: got %0b expected 0", v, stall);
      end
      @(negedge clk);
      set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (ex_alu_op !== 4'd1 || ex_rd !== 4'd6 || cnt !== 16'd0) begin
        errors++;
        $display("FAIL nohaz_ex_%0d: got alu=%0d rd=%0d cnt=%0d expected 1 6 0",
                 v, ex_alu_op, ex_rd, cnt);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(8'h81, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(8'h91, 4'd6, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL flush_prio: got stall=%0b flush=%0b expected 0 1", stall, flush);
    end
    @(negedge clk);
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ex_alu_op !== 4'd0 || ex_rd !== 4'd0 || cnt !== 16'd1 || flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got alu=%0d rd=%0d cnt=%0d flush=%0b expected 0 0 1 0",
               ex_alu_op, ex_rd, cnt, flush);
    end
    @(negedge clk); #1;
    checks++;
    if (ex_alu_op !== 4'd0 || ex_rd !== 4'd0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_discard: got alu=%0d rd=%0d cnt=%0d expected 0 0 1",
               ex_alu_op, ex_rd, cnt);
    end
  endtask

  task automatic test_store_reset();
    do_reset();
    set_in(8'h40, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (mem_wme !== 1'b0) begin
      errors++; $display("FAIL str_early: got wme=%0b expected 0", mem_wme);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_wme !== 1'b1) begin
      errors++; $display("FAIL str_mem_wme: got wme=%0b expected 1", mem_wme);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_wme !== 1'b0 || dut_vec !== 23'h0) begin
      errors++;
      $display("FAIL str_async_reset: got wme=%0b vec=%h expected 0 0", mem_wme, dut_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(8'h81, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      set_in(8'h91, 4'd7, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
    end
    set_in(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (cnt !== 16'd5) begin
      errors++; $display("FAIL sat_cnt16: got %0d expected 5", cnt);
    end
    checks++;
    if (s_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_cnt2: got %0d expected 3", s_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [3:0] s1, s2;
    int unsigned e16, e2;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'h91;
        2: c = 8'h81;
        3: c = 8'h40;
        4: c = 8'h02;
        default: c = 8'($urandom);
      endcase
      s1 = ($urandom_range(0, 1) == 1) ? hist[0][3:0] : 4'($urandom);
      s2 = ($urandom_range(0, 1) == 1) ? hist[0][3:0] : 4'($urandom);
      set_in(c, 4'($urandom), s1, s2, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0));
      #1;
      e16 = (bubbles > 65535) ? 65535 : bubbles;
      e2  = (bubbles > 3) ? 3 : bubbles;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_outputs[%0d]: got %h expected %h", n, dut_vec, exp_vec());
      end
      checks++;
      if (sat_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_outputs_sat[%0d]: got %h expected %h", n, sat_vec, exp_vec());
      end
      checks++;
      if (cnt !== 16'(e16) || s_cnt !== 2'(e2)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                 n, cnt, s_cnt, e16, e2);
      end
      cycle();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_flow();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_store_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer side of the decode control bundle. Takes the 8-bit control word produced in ID, plus register addresses, and carries it through the ID/EX, EX/MEM and MEM/WB registers.
- At each stage it presents the unpacked fields the datapath needs.
- Detects load-use hazards and inserts bubbles (the NOP bundle) on stall or branch flush.
- Sits between the control unit and the execute, memory and writeback datapath stages.

Parameters:
- REG_AW, 4: register-address width.
- CNT_W, 16: width of the saturating bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ctrl_i  in  8  control bundle from decode: {wre, wme, wb_sel[1:0], alu_op[3:0]}.
- id_rd_i  in  REG_AW  destination register of the ID instruction.
- id_rs1_i  in  REG_AW  source 1 of the ID instruction.
- id_rs2_i  in  REG_AW  source 2 of the ID instruction.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- branch_taken_i  in  1  be resolved taken in EX this cycle.
- stall_o  out  1  hold PC and IF/ID this cycle.
- flush_o  out  1  clear IF/ID; equals branch_taken_i.
- ex_alu_op_o  out  4  ALU operation for EX.
- ex_rd_o  out  REG_AW  destination in EX (for forwarding).
- mem_wme_o  out  1  data-memory write enable.
- mem_wre_o  out  1  register write pending in MEM (for forwarding).
- mem_rd_o  out  REG_AW  destination in MEM.
- wb_wre_o  out  1  register-file write enable.
- wb_sel_o  out  2  writeback mux select: 00 = memory, 01 = ALU.
- wb_rd_o  out  REG_AW  register-file write address.
- bubble_cnt_o  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All three stage bundles are set to 8'h00 and all rd fields to 0.
  - bubble_cnt_o is set to 0.
  - Consequently every output is 0, including stall_o.
  - Reset asserted mid-stream discards all in-flight instructions immediately; no partial writes are issued after the reset edge.
- Pipeline advance: every rising clk, MEM/WB <= EX/MEM and EX/MEM <= ID/EX, unconditionally.
  - EX/MEM and MEM/WB never stall.
- ID/EX load: on each rising clk, ID/EX receives one of the following, in priority order:
  - the bubble (8'h00, rd=0) if branch_taken_i = 1;
  - the bubble if stall_o = 1;
  - otherwise {id_ctrl_i, id_rd_i}.
- Load detection: ex_is_load = ex.wre & (ex.wb_sel == 2'b00).
- stall_o (combinational):
  - stall_o = ex_is_load & ~branch_taken_i & ((id_rs1_used_i & id_rs1_i == ex_rd) | (id_rs2_used_i & id_rs2_i == ex_rd)).
  - Register 0 gets no special treatment.
- Stall length is exactly 1 cycle. The inserted bubble is not a load, so stall_o deasserts on the next cycle and the held instruction enters EX.
- Flush:
  - branch_taken_i has priority over stall; the ID instruction is discarded, not held.
  - Simultaneous flush and hazard gives stall_o = 0 and one bubble.
- bubble_cnt_o:
  - Increments by 1 on each clock edge at which a bubble is loaded because of a stall or a flush.
  - It is not incremented for NOP bundles arriving from decode.
  - Saturates at all-ones; it does not wrap.
- Latency: fields of id_ctrl_i appear at EX outputs 1 cycle after capture, at MEM outputs after 2 cycles, and at WB outputs after 3 cycles.
- Bundles are passed through unchecked; wre = wme = 1 is carried as-is.

Decomposition:
- Package ctrl_pkg contains:
  - packed struct ctrl_bundle_t {wre, wme, wb_sel[1:0], alu_op[3:0]};
  - CTRL_NOP = 8'h00;
  - WB_SEL_MEM = 2'b00 and WB_SEL_ALU = 2'b01;
  - ALU_NOP = 4'b0000 and ALU_ADD = 4'b0001;
  - opcode constants OP_NOP, OP_ADD, OP_BE, OP_LDR, OP_STR.
- One sub-module, ctrl_stage_reg:
  - bundle plus rd register with async active-low clear and a synchronous bubble-load input;
  - instantiated three times (ID/EX, EX/MEM, MEM/WB).
- Hazard detection and the counter stay inline in ctrl_pipe.

Test Plan:
- Reset: hold rst_n = 0 with id_ctrl_i = 8'h91 and a running clock -> all outputs 0 and bubble_cnt_o = 0. Release reset -> first capture on the next edge.
- Add flow: id_ctrl_i = 8'h91 (add), rd = 5 -> after 1 edge ex_alu_op_o = 1, ex_rd_o = 5; after 2 edges mem_wre_o = 1, mem_rd_o = 5; after 3 edges wb_wre_o = 1, wb_sel_o = 01, wb_rd_o = 5.
- Load-use hazard: ldr 8'h81, rd = 3, then add with rs1 = 3, rs1_used = 1:
  - stall_o = 1 for exactly one cycle; EX shows alu_op 0 for that cycle.
  - The add reaches EX one cycle later; bubble_cnt_o = 1.
- No hazard: same sequence but rs1_used = 0 (or rs1 = 4) -> stall_o stays 0 and bubble_cnt_o stays 0.
- Flush priority: ldr rd = 3 in EX, ID add reads r3, branch_taken_i = 1 in the same cycle -> stall_o = 0, flush_o = 1, EX next cycle = 8'h00, the add is never seen in EX, bubble_cnt_o increments by 1.
- Store and mid-stream reset: str 8'h40 -> mem_wme_o = 1 exactly 2 edges later. Assert rst_n low while the str is in MEM -> mem_wme_o drops immediately, not at the next edge.
- Counter saturation (run with CNT_W = 2): force 5 stalls -> bubble_cnt_o = 3.
